sr_ff: RTL and testbench
========================

Name: sr_ff

Overview:
- Clocked set/reset flip-flop bank: WIDTH independent SR storage bits, updated on the rising edge of clk.
- Provides true output q and complementary output qb.
- Resolves the forbidden S=R=1 input combination deterministically and flags it.
- Used as a generic state/flag-holding primitive wherever set/clear-style control is needed.

Parameters:
- WIDTH, 1, number of independent SR bits; all data ports are WIDTH wide.
- SR11_MODE, 0, per-bit policy when s=1 and r=1 are sampled together: 0 = hold, 1 = set-dominant, 2 = reset-dominant, 3 = toggle.
- RESET_VAL, 0 (all zeros), WIDTH-bit value loaded into q on reset.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- s  input  WIDTH  per-bit set request
- r  input  WIDTH  per-bit reset request
- q  output  WIDTH  stored state
- qb  output  WIDTH  complement of q, always exactly ~q
- invalid  output  WIDTH  per-bit flag, registered: 1 if s=r=1 was sampled on that bit at the last clock edge

Behaviour:
- Reset:
  - rst_n low forces q=RESET_VAL, qb=~RESET_VAL and invalid=0 immediately, with no clock required.
  - Outputs are held at these values while rst_n stays low.
  - Reset deassertion is synchronous to the design environment; the first update happens on the first rising clk edge after rst_n goes high.
- Per bit i, at each rising clk edge while rst_n is high:
  - s=0, r=0: q holds.
  - s=0, r=1: q <= 0.
  - s=1, r=0: q <= 1.
  - s=1, r=1: q follows SR11_MODE (hold / 1 / 0 / ~q). invalid[i] <= 1.
  - Any other combination: invalid[i] <= 0.
- Outputs:
  - qb is combinational ~q; there is never a cycle where q and qb are equal, including during reset.
  - Latency: a change on s or r appears on q one clock edge later. Input changes between edges have no effect (edge-triggered, not level-sensitive).
- No X propagation: every input combination gives a defined next state. An X or Z on s or r is a bench error and is not handled.
- Bits are fully independent; there is no cross-bit interaction.
- Reset mid-operation:
  - Asynchronous assertion overrides any pending update.
  - A clock edge coinciding with rst_n low produces no update.
- Timing: inputs must meet setup/hold relative to the rising clk edge. The bench changes inputs on falling edges or midway between rising edges.

Test Plan:
- Reset: rst_n=0 with clk running, s=1, r=0 -> q=0, qb=1, invalid=0 throughout. Release rst_n -> q=1 at the next rising edge.
- Sequence with WIDTH=1, SR11_MODE=0, 10 ns clock period, inputs changed every 10 ns. After reset, apply (s,r) = 00, 01, 10, 00, 01, 11 in turn:
  - q after each following rising edge is 0, 0, 1, 1, 0, 0.
  - invalid is 1 only after the 11 edge.
  - qb=~q at every sample.
- Forbidden-input policies: starting from q=1, apply s=r=1 for one edge:
  - SR11_MODE=0 -> q=1.
  - SR11_MODE=1 -> q=1.
  - SR11_MODE=2 -> q=0.
  - SR11_MODE=3 -> q=0; hold s=r=1 for a second edge -> q=1.
  - invalid=1 in every case.
- Mid-cycle glitch: s pulses 0->1->0 entirely between two rising edges -> q unchanged.
- Asynchronous reset mid-operation: q=1, assert rst_n low midway between edges -> q=0 and qb=1 immediately, before the next edge.
- Multi-bit independence, WIDTH=4, from q=0000:
  - Apply s=1010, r=0110 -> q=1000, invalid=0010.
  - Then s=0000, r=0000 -> q=1000, invalid=0000.

Source files
------------

// File: rtl/sr_ff.sv
// Bank of WIDTH independent clocked set/reset bits with complementary outputs.
// A simultaneous set+clear is resolved by SR11_MODE and flagged on invalid.
module sr_ff #(
  parameter int               WIDTH     = 1,
  parameter int               SR11_MODE = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] invalid
);

  logic [WIDTH-1:0] q_next;

  // Out-of-range SR11_MODE values fall back to hold on a forbidden input.
  always_comb begin
    q_next = q;
    for (int i = 0; i < WIDTH; i++) begin
      unique case ({s[i], r[i]})
        2'b00: q_next[i] = q[i];
        2'b01: q_next[i] = 1'b0;
        2'b10: q_next[i] = 1'b1;
        default: begin
          if (SR11_MODE == 1)      q_next[i] = 1'b1;
          else if (SR11_MODE == 2) q_next[i] = 1'b0;
          else if (SR11_MODE == 3) q_next[i] = ~q[i];
          else                     q_next[i] = q[i];
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= RESET_VAL;
      invalid <= '0;
    end else begin
      q       <= q_next;
      invalid <= s & r;
    end
  end

  assign qb = ~q;

endmodule

// File: tb/tb_sr_ff.sv
// Self-checking bench for sr_ff: four WIDTH=4 instances, one per SR11_MODE,
// sharing inputs and compared against a bitwise set/clear reference model.
module tb_sr_ff;

  localparam int         N = 4;
  localparam logic [3:0] RV [N] = '{4'h0, 4'hA, 4'h0, 4'h5};

  logic       clk;
  logic       rst_n;
  logic [3:0] s;
  logic [3:0] r;
  logic [3:0] q_o   [N];
  logic [3:0] qb_o  [N];
  logic [3:0] inv_o [N];

  logic [3:0] mq   [N];
  logic [3:0] minv [N];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    sr_ff #(.WIDTH(4), .SR11_MODE(g), .RESET_VAL(RV[g])) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .s       (s),
      .r       (r),
      .q       (q_o[g]),
      .qb      (qb_o[g]),
      .invalid (inv_o[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // Reference: set wins bits with s only, clear wins bits with r only,
  // and bits with both follow the instance's forbidden-input policy.
  task automatic model_update(input logic [3:0] sv, input logic [3:0] rv);
    logic [3:0] both, nq;
    both = sv & rv;
    for (int k = 0; k < N; k++) begin
      nq = (mq[k] | (sv & ~rv)) & ~(rv & ~sv);
      case (k)
        1:       nq = nq | both;
        2:       nq = nq & ~both;
        3:       nq = nq ^ both;
        default: nq = nq;
      endcase
      mq[k]   = nq;
      minv[k] = both;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mq[k]   = RV[k];
      minv[k] = 4'h0;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] sv, input logic [3:0] rv);
    @(negedge clk);
    s = sv;
    r = rv;
    @(posedge clk);
    if (rst_n) model_update(sv, rv);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    s = 4'hF;
    r = 4'h0;
    #2 rst_n = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        checks++; if (q_o[k] !== RV[k]) begin errors++; $display("FAIL reset q[%0d] got %h want %h", k, q_o[k], RV[k]); end
        checks++; if (qb_o[k] !== ~RV[k]) begin errors++; $display("FAIL reset qb[%0d] got %h want %h", k, qb_o[k], ~RV[k]); end
        checks++; if (inv_o[k] !== 4'h0) begin errors++; $display("FAIL reset inv[%0d] got %h want 0", k, inv_o[k]); end
      end
    end
    rst_n = 1'b1;
    applyStimulus(4'hF, 4'h0);
    for (int k = 0; k < N; k++) begin
      checks++; if (q_o[k] !== 4'hF) begin errors++; $display("FAIL reset_release q[%0d] got %h want f", k, q_o[k]); end
    end
  endtask

  task automatic test_sequence();
    logic [1:0] pat  [6] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b11};
    logic       expq [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus({4{pat[i][1]}}, {4{pat[i][0]}});
      checks++; if (q_o[0][0] !== expq[i]) begin errors++; $display("FAIL seq q step %0d got %b want %b", i, q_o[0][0], expq[i]); end
      checks++; if (inv_o[0][0] !== (i == 5)) begin errors++; $display("FAIL seq inv step %0d got %b want %b", i, inv_o[0][0], (i == 5)); end
      for (int k = 0; k < N; k++) begin
        checks++; if (q_o[k] !== mq[k]) begin errors++; $display("FAIL seq q[%0d] got %h want %h", k, q_o[k], mq[k]); end
        checks++; if (qb_o[k] !== ~mq[k]) begin errors++; $display("FAIL seq qb[%0d] got %h want %h", k, qb_o[k], ~mq[k]); end
        checks++; if (inv_o[k] !== minv[k]) begin errors++; $display("FAIL seq inv[%0d] got %h want %h", k, inv_o[k], minv[k]); end
      end
    end
  endtask

  task automatic test_policies();
    logic [3:0] exp1 [N] = '{4'hF, 4'hF, 4'h0, 4'h0};
    applyStimulus(4'hF, 4'h0);
    applyStimulus(4'hF, 4'hF);
    for (int k = 0; k < N; k++) begin
      checks++; if (q_o[k] !== exp1[k]) begin errors++; $display("FAIL policy q[%0d] got %h want %h", k, q_o[k], exp1[k]); end
      checks++; if (inv_o[k] !== 4'hF) begin errors++; $display("FAIL policy inv[%0d] got %h want f", k, inv_o[k]); end
    end
    applyStimulus(4'hF, 4'hF);
    checks++; if (q_o[3] !== 4'hF) begin errors++; $display("FAIL policy_toggle2 q got %h want f", q_o[3]); end
    for (int k = 0; k < N; k++) begin
      checks++; if (q_o[k] !== mq[k]) begin errors++; $display("FAIL policy2 q[%0d] got %h want %h", k, q_o[k], mq[k]); end
      checks++; if (inv_o[k] !== 4'hF) begin errors++; $display("FAIL policy2 inv[%0d] got %h want f", k, inv_o[k]); end
    end
  endtask

  task automatic test_glitch();
    applyStimulus(4'h0, 4'hF);
    applyStimulus(4'h0, 4'h0);
    #1 s = 4'hF;
    #2 s = 4'h0;
    @(posedge clk);
    model_update(4'h0, 4'h0);
    #1;
    for (int k = 0; k < N; k++) begin
      checks++; if (q_o[k] !== mq[k]) begin errors++; $display("FAIL glitch q[%0d] got %h want %h", k, q_o[k], mq[k]); end
      checks++; if (inv_o[k] !== 4'h0) begin errors++; $display("FAIL glitch inv[%0d] got %h want 0", k, inv_o[k]); end
    end
  endtask

  task automatic test_async_reset();
    applyStimulus(4'hF, 4'h0);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (q_o[0] !== 4'h0) begin errors++; $display("FAIL async q got %h want 0", q_o[0]); end
    for (int k = 0; k < N; k++) begin
      checks++; if (q_o[k] !== RV[k]) begin errors++; $display("FAIL async q[%0d] got %h want %h", k, q_o[k], RV[k]); end
      checks++; if (qb_o[k] !== ~RV[k]) begin errors++; $display("FAIL async qb[%0d] got %h want %h", k, qb_o[k], ~RV[k]); end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      checks++; if (q_o[k] !== RV[k]) begin errors++; $display("FAIL async_edge q[%0d] got %h want %h", k, q_o[k], RV[k]); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_independence();
    do_reset();
    applyStimulus(4'b1010, 4'b0110);
    checks++; if (q_o[0] !== 4'b1000) begin errors++; $display("FAIL indep q got %b want 1000", q_o[0]); end
    checks++; if (inv_o[0] !== 4'b0010) begin errors++; $display("FAIL indep inv got %b want 0010", inv_o[0]); end
    applyStimulus(4'b0000, 4'b0000);
    checks++; if (q_o[0] !== 4'b1000) begin errors++; $display("FAIL indep_hold q got %b want 1000", q_o[0]); end
    checks++; if (inv_o[0] !== 4'b0000) begin errors++; $display("FAIL indep_hold inv got %b want 0000", inv_o[0]); end
    for (int k = 0; k < N; k++) begin
      checks++; if (q_o[k] !== mq[k]) begin errors++; $display("FAIL indep q[%0d] got %h want %h", k, q_o[k], mq[k]); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      applyStimulus(4'($urandom), 4'($urandom));
      for (int k = 0; k < N; k++) begin
        checks++; if (q_o[k] !== mq[k]) begin errors++; $display("FAIL rand q[%0d] got %h want %h", k, q_o[k], mq[k]); end
        checks++; if (qb_o[k] !== ~mq[k]) begin errors++; $display("FAIL rand qb[%0d] got %h want %h", k, qb_o[k], ~mq[k]); end
        checks++; if (inv_o[k] !== minv[k]) begin errors++; $display("FAIL rand inv[%0d] got %h want %h", k, inv_o[k], minv[k]); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    s     = 4'h0;
    r     = 4'h0;
    model_reset();
    test_reset();
    test_sequence();
    test_policies();
    test_glitch();
    test_async_reset();
    test_independence();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
